// File: rtl/exa_crosb_output_vc_credit_arbiter.sv
// Per-output crossbar arbiter. It picks one (input, prio, VC) among the requests whose VC has a credit.
// It runs round-robin per priority, promotes starved priorities by aging, and locks the grant for a whole packet.
module exa_crosb_output_vc_credit_arbiter #(
    parameter int INPUT_NUM = 4,
    parameter int PRIO_NUM  = 2,
    parameter int VC_NUM    = 2,
    parameter int AGE_LIMIT = 8,
    localparam int CLS   = PRIO_NUM * VC_NUM,
    localparam int PAIRS = INPUT_NUM * VC_NUM,
    localparam int IW    = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
    localparam int CW    = (CLS > 1) ? $clog2(CLS) : 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [INPUT_NUM*CLS-1:0] i_request,
    input  logic [CLS-1:0]           i_credit,
    input  logic                     i_accept,
    input  logic                     i_valid,
    input  logic                     i_last,
    output logic [INPUT_NUM-1:0]     o_grant,
    output logic [IW-1:0]            o_input_sel,
    output logic [CW-1:0]            o_class_sel,
    output logic                     o_cts,
    output logic                     o_busy
);
    localparam int KW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int PW = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1;
    localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_e;

    state_e                          state_q;
    logic [INPUT_NUM-1:0]            grant_q;
    logic [IW-1:0]                   in_sel_q;
    logic [CW-1:0]                   cls_sel_q;
    logic                            cts_q, busy_q;
    logic [PW-1:0]                   dec_p_q;
    logic [KW-1:0]                   dec_k_q;
    logic [PRIO_NUM-1:0]             dec_act_q;
    logic [KW-1:0]                   rr_ptr_q [PRIO_NUM];
    logic [AW-1:0]                   age_q    [PRIO_NUM];

    logic [PRIO_NUM-1:0][PAIRS-1:0]  pair_elig;
    logic [PRIO_NUM-1:0]             active, aged;
    logic                            any_active, any_aged;
    logic [PW-1:0]                   win_p;
    logic [KW-1:0]                   win_k;
    logic [IW-1:0]                   win_in;
    logic [CW-1:0]                   win_cls;
    logic [INPUT_NUM-1:0]            win_grant;

    // Regroup requests per priority into (input, VC) pair vectors, pair k = i*VC_NUM + v.
    always_comb begin
        pair_elig = '0;
        for (int p = 0; p < PRIO_NUM; p++)
            for (int i = 0; i < INPUT_NUM; i++)
                for (int v = 0; v < VC_NUM; v++)
                    pair_elig[p][i*VC_NUM+v] = i_request[i*CLS + p*VC_NUM + v] & i_credit[p*VC_NUM + v];
    end

    always_comb begin
        active   = '0;
        aged     = '0;
        any_aged = 1'b0;
        win_p    = '0;
        for (int p = 0; p < PRIO_NUM; p++) begin
            active[p] = |pair_elig[p];
            aged[p]   = (AGE_LIMIT > 0) && active[p] && (age_q[p] >= AW'(AGE_LIMIT));
        end
        any_active = |active;
        // Ascending scan, so the highest qualifying priority is the one left in win_p.
        for (int p = 0; p < PRIO_NUM; p++)
            if (aged[p]) begin
                win_p    = PW'(p);
                any_aged = 1'b1;
            end
        if (!any_aged)
            for (int p = 0; p < PRIO_NUM; p++)
                if (active[p]) win_p = PW'(p);
    end

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        win_k = '0;
        for (int off = 0; off < PAIRS; off++) begin
            idx = (int'(rr_ptr_q[win_p]) + off) % PAIRS;
            if (!found && pair_elig[win_p][idx]) begin
                win_k = KW'(idx);
                found = 1'b1;
            end
        end
        win_in            = IW'(int'(win_k) / VC_NUM);
        win_cls           = CW'(int'(win_p) * VC_NUM + int'(win_k) % VC_NUM);
        win_grant         = '0;
        win_grant[win_in] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            in_sel_q  <= '0;
            cls_sel_q <= '0;
            cts_q     <= 1'b0;
            busy_q    <= 1'b0;
            dec_p_q   <= '0;
            dec_k_q   <= '0;
            dec_act_q <= '0;
            for (int p = 0; p < PRIO_NUM; p++) begin
                rr_ptr_q[p] <= '0;
                age_q[p]    <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_active) begin
                        state_q   <= OFFER;
                        grant_q   <= win_grant;
                        in_sel_q  <= win_in;
                        cls_sel_q <= win_cls;
                        cts_q     <= 1'b1;
                        dec_p_q   <= win_p;
                        dec_k_q   <= win_k;
                        dec_act_q <= active;
                    end
                end
                OFFER: begin
                    if (!i_accept) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        cts_q   <= 1'b0;
                    end else begin
                        rr_ptr_q[dec_p_q] <= KW'((int'(dec_k_q) + 1) % PAIRS);
                        // Only priorities that lost this decision age; the winner restarts from zero.
                        for (int q = 0; q < PRIO_NUM; q++) begin
                            if (PW'(q) == dec_p_q)
                                age_q[q] <= '0;
                            else if (dec_act_q[q] && (age_q[q] < AW'(AGE_LIMIT)))
                                age_q[q] <= age_q[q] + 1'b1;
                        end
                        if (i_valid && i_last) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            cts_q   <= 1'b0;
                        end else begin
                            state_q <= LOCKED;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (i_valid && i_last) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        cts_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    cts_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant     = grant_q;
    assign o_input_sel = in_sel_q;
    assign o_class_sel = cls_sel_q;
    assign o_cts       = cts_q;
    assign o_busy      = busy_q;
endmodule
